// File: rtl/mips_defs_pkg.sv
// Shared MIPS datapath definitions: word/address widths, zero constants and a commit helper.
package mips_defs_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NREG       = 2 ** REG_ADDR_W;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam word_t     ZERO_WORD = 32'd0;
    localparam reg_addr_t REG_ZERO  = 5'd0;

    // A GPR write retires only when enabled and not aimed at the hard-wired zero register
    function automatic logic gpr_commit(input logic en, input reg_addr_t addr);
        return en && (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/hilo_reg.sv
// HI/LO storage: both halves written together, optional same-cycle bypass (RF_BYPASS_EN).
module hilo_reg
    import mips_defs_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hilo_en,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    // Next-state: load both halves on a HI/LO write
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hilo_en) begin
            hi_d = hi_in;
            lo_d = lo_in;
        end
    end

    // HI/LO registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Read side: zero during reset, otherwise stored value or the in-flight write
    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
`ifdef RF_BYPASS_EN
        if (hilo_en) begin
            hi_o = hi_in;
            lo_o = lo_in;
        end
`endif
        if (!reset_n) begin
            hi_o = '0;
            lo_o = '0;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: GPR array, two decode read ports, HI/LO and a retired-write counter.
// Define RF_BYPASS_EN to forward same-cycle writes to the read ports and HI/LO outputs.
module wb_regfile
    import mips_defs_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_hilo_en,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic              rd2_en,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [31:0]       wr_count
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] gpr_q [NUM_REGS];
    logic [DATA_W-1:0] gpr_d [NUM_REGS];
    logic [31:0]       wr_count_q, wr_count_d;
    logic              commit;

    assign commit = wb_en && (wb_addr != '0);

    // Next-state: apply the committed GPR write and bump the retire counter
    always_comb begin
        gpr_d      = gpr_q;
        wr_count_d = wr_count_q;
        if (commit) begin
            gpr_d[wb_addr] = wb_data;
            wr_count_d     = wr_count_q + 32'd1;
        end
        gpr_d[0] = '0;
    end

    // GPR array and counter registers; reset overrides any write in the same cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gpr_q      <= '{default: '0};
            wr_count_q <= 32'd0;
        end else begin
            gpr_q      <= gpr_d;
            wr_count_q <= wr_count_d;
        end
    end

    // One read port: zero when disabled, addressing r0 or in reset; optionally forwards wb_data
    function automatic logic [DATA_W-1:0] read_port(input logic en, input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = gpr_q[addr];
`ifdef RF_BYPASS_EN
        if (commit && (addr == wb_addr)) begin
            val = wb_data;
        end
`endif
        if (!reset_n || !en || (addr == '0)) begin
            val = '0;
        end
        return val;
    endfunction

    // Combinational decode-stage read ports
    always_comb begin
        rd1_data = read_port(rd1_en, rd1_addr);
        rd2_data = read_port(rd2_en, rd2_addr);
    end

    assign wr_count = wr_count_q;

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk     (clk),
        .reset_n (reset_n),
        .hilo_en (wb_hilo_en),
        .hi_in   (wb_hi),
        .lo_in   (wb_lo),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios then randomized traffic against a behavioural model.
module tb_wb_regfile;

    logic        clk;
    logic        reset_n;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_hilo_en;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        rd1_en;
    logic [4:0]  rd1_addr;
    logic [31:0] rd1_data;
    logic        rd2_en;
    logic [4:0]  rd2_addr;
    logic [31:0] rd2_data;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] wr_count;

    wb_regfile dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_hilo_en (wb_hilo_en),
        .wb_hi      (wb_hi),
        .wb_lo      (wb_lo),
        .rd1_en     (rd1_en),
        .rd1_addr   (rd1_addr),
        .rd1_data   (rd1_data),
        .rd2_en     (rd2_en),
        .rd2_addr   (rd2_addr),
        .rd2_data   (rd2_data),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the architectural state
    logic [31:0] m_gpr [32];
    logic [31:0] m_hi, m_lo, m_cnt;
    int n_vec = 0;
    int n_err = 0;

    `ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
    `else
    localparam bit BYPASS = 1'b0;
    `endif

    function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] addr);
        if (!reset_n || !en || addr == 5'd0) return 32'd0;
        if (BYPASS && wb_en && wb_addr != 5'd0 && addr == wb_addr) return wb_data;
        return m_gpr[addr];
    endfunction

    function automatic logic [31:0] exp_hi();
        if (!reset_n) return 32'd0;
        if (BYPASS && wb_hilo_en) return wb_hi;
        return m_hi;
    endfunction

    function automatic logic [31:0] exp_lo();
        if (!reset_n) return 32'd0;
        if (BYPASS && wb_hilo_en) return wb_lo;
        return m_lo;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reads(input string tag);
        chk({tag, ".rd1"}, rd1_data, exp_rd(rd1_en, rd1_addr));
        chk({tag, ".rd2"}, rd2_data, exp_rd(rd2_en, rd2_addr));
        chk({tag, ".hi"},  hi_o,     exp_hi());
        chk({tag, ".lo"},  lo_o,     exp_lo());
    endtask

    // Advance one clock: model commits what the DUT sees at the edge, then counter is checked
    task automatic cycle(input string tag);
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
            m_hi  = 32'd0;
            m_lo  = 32'd0;
            m_cnt = 32'd0;
        end else begin
            if (wb_en && wb_addr != 5'd0) begin
                m_gpr[wb_addr] = wb_data;
                m_cnt          = m_cnt + 32'd1;
            end
            if (wb_hilo_en) begin
                m_hi = wb_hi;
                m_lo = wb_lo;
            end
        end
        #1;
        chk({tag, ".wr_count"}, wr_count, m_cnt);
        @(negedge clk);
    endtask

    task automatic idle();
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        wb_hilo_en = 1'b0; wb_hi = 32'd0; wb_lo = 32'd0;
        rd1_en = 1'b0; rd1_addr = 5'd0; rd2_en = 1'b0; rd2_addr = 5'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'hXXXX_XXXX;
        m_hi = 'x; m_lo = 'x; m_cnt = 'x;
        idle();
        reset_n = 1'b0;
        @(negedge clk);

        // 1. Reset for 2 clk; outputs forced to zero even with enables and a pending write
        rd1_en = 1'b1; rd1_addr = 5'd4; rd2_en = 1'b1; rd2_addr = 5'd9;
        wb_hilo_en = 1'b1; wb_hi = 32'h55; wb_lo = 32'h66;
        cycle("reset0");
        #1;
        chk("reset.rd1_forced", rd1_data, 32'd0);
        chk("reset.hi_forced",  hi_o,     32'd0);
        cycle("reset1");
        idle();
        reset_n = 1'b1;
        rd1_en = 1'b1; rd2_en = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rd1_addr = 5'(a);
            rd2_addr = 5'(31 - a);
            #1;
            chk("reset.rd1", rd1_data, 32'd0);
            chk("reset.rd2", rd2_data, 32'd0);
        end
        chk("reset.hi", hi_o, 32'd0);
        chk("reset.lo", lo_o, 32'd0);
        chk("reset.cnt", wr_count, 32'd0);

        // 2. Write r5, read on both ports next cycle
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        cycle("w5");
        idle();
        rd1_en = 1'b1; rd1_addr = 5'd5; rd2_en = 1'b1; rd2_addr = 5'd5;
        #1;
        chk("w5.rd1", rd1_data, 32'hDEAD_BEEF);
        chk("w5.rd2", rd2_data, 32'hDEAD_BEEF);
        chk("w5.cnt", wr_count, 32'd1);

        // 3. Write to r0 is dropped and not counted
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
        rd1_addr = 5'd0;
        cycle("w0");
        wb_en = 1'b0;
        #1;
        chk("w0.rd1", rd1_data, 32'd0);
        chk("w0.cnt", wr_count, 32'd1);

        // 4. Same-cycle write/read of r7
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5_A5A5;
        rd1_en = 1'b1; rd1_addr = 5'd7;
        #1;
        chk("byp.rd1", rd1_data, BYPASS ? 32'hA5A5_A5A5 : 32'd0);
        check_reads("byp");
        cycle("byp");
        wb_en = 1'b0;
        #1;
        chk("byp.after", rd1_data, 32'hA5A5_A5A5);

        // 5. HI/LO and GPR write in the same cycle
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h3;
        wb_hilo_en = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
        #1;
        check_reads("hilo.wcyc");
        cycle("hilo");
        idle();
        rd2_en = 1'b1; rd2_addr = 5'd3;
        #1;
        chk("hilo.hi",   hi_o,     32'h1);
        chk("hilo.lo",   lo_o,     32'h2);
        chk("hilo.gpr3", rd2_data, 32'h3);
        chk("hilo.cnt",  wr_count, 32'd3);

        // 6. Counter wrap from all-ones
        force dut.wr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count_q;
        m_cnt = 32'hFFFF_FFFF;
        #1;
        chk("wrap.pre", wr_count, 32'hFFFF_FFFF);
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hCAFE_0001;
        cycle("wrap");
        chk("wrap.cnt", wr_count, 32'd0);

        // Reset asserted during a write to r9: nothing commits
        wb_addr = 5'd9; wb_data = 32'h9999_9999;
        reset_n = 1'b0;
        cycle("rstw");
        reset_n = 1'b1;
        wb_en = 1'b0;
        rd1_en = 1'b1; rd1_addr = 5'd9; rd2_en = 1'b1; rd2_addr = 5'd1;
        #1;
        chk("rstw.gpr9", rd1_data, 32'd0);
        chk("rstw.gpr1", rd2_data, 32'd0);
        chk("rstw.cnt",  wr_count, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset_n    = ($urandom_range(0, 59) != 0);
            wb_en      = 1'($urandom_range(0, 3) != 0);
            wb_addr    = 5'($urandom);
            wb_data    = $urandom;
            wb_hilo_en = 1'($urandom_range(0, 3) == 0);
            wb_hi      = $urandom;
            wb_lo      = $urandom;
            rd1_en     = 1'($urandom_range(0, 7) != 0);
            rd2_en     = 1'($urandom_range(0, 7) != 0);
            rd1_addr   = ($urandom_range(0, 2) == 0) ? wb_addr : 5'($urandom);
            rd2_addr   = ($urandom_range(0, 3) == 0) ? rd1_addr : 5'($urandom);
            #1;
            check_reads("rand");
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
